// File: rtl/seg7_capture_static.sv
// Captures a time-multiplexed abcdefgh/digit-strobe bus into static per-digit segment outputs,
// with staleness blanking and optional brightness PWM (SEG7_CAPTURE_BRIGHTNESS_PWM_EN).
module seg7_capture_static #(
    parameter int w_digit        = 8,
    parameter bit seg_active_low = 1'b1,
    parameter bit dp_active_low  = 1'b0,
    parameter bit reverse_bits   = 1'b1,
    parameter int timeout_cycles = 50_000_000,
    parameter int w_bright       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             abcdefgh,
    input  logic [w_digit-1:0]     digit,
    input  logic [w_bright-1:0]    brightness,
    output logic [7*w_digit-1:0]   hex_seg,
    output logic [w_digit-1:0]     dp,
    output logic [w_digit-1:0]     stale
);

    localparam int CW = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;

    logic                        en_d;
    logic [w_digit-1:0][7:0]     pat_q, pat_d;
    logic [w_digit-1:0]          stale_q, stale_d;
    logic [w_digit-1:0][6:0]     seg_q, seg_d;
    logic [w_digit-1:0]          dp_q, dp_d;

`ifdef SEG7_CAPTURE_BRIGHTNESS_PWM_EN
    logic [w_bright-1:0] pwm_q, pwm_d, bri_q, bri_d;

    // brightness is only sampled at the period boundary so a duty change never splits a period
    assign pwm_d = pwm_q + w_bright'(1);
    assign bri_d = (pwm_d == '0) ? brightness : bri_q;
    assign en_d  = (&bri_d) | (pwm_d < bri_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= '0;
            bri_q <= '0;
        end else begin
            pwm_q <= pwm_d;
            bri_q <= bri_d;
        end
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign en_d = 1'b1;
`endif

    if (timeout_cycles > 0) begin : g_to
        localparam logic [CW-1:0] TMAX = CW'(timeout_cycles);
        for (genvar i = 0; i < w_digit; i++) begin : g_cnt
            logic [CW-1:0] cnt_q, cnt_d, inc;

            // a strobe on the cycle the count would hit TMAX wins over going stale
            assign inc        = (cnt_q == TMAX) ? TMAX : cnt_q + CW'(1);
            assign cnt_d      = digit[i] ? '0 : inc;
            assign stale_d[i] = ~digit[i] & (stale_q[i] | (inc == TMAX));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end
        end
    end else begin : g_nto
        assign stale_d = stale_q & ~digit;
    end

    // Outputs are decoded from next-state so the display updates on the capturing edge.
    always_comb begin
        logic show;
        logic lit;
        show  = 1'b0;
        lit   = 1'b0;
        pat_d = pat_q;
        seg_d = '0;
        dp_d  = '0;
        for (int i = 0; i < w_digit; i++) begin
            pat_d[i] = digit[i] ? abcdefgh : pat_q[i];
            show     = ~stale_d[i] & en_d;
            for (int k = 0; k < 7; k++) begin
                lit         = reverse_bits ? pat_d[i][7-k] : pat_d[i][k];
                seg_d[i][k] = (lit & show) ^ seg_active_low;
            end
            lit     = reverse_bits ? pat_d[i][0] : pat_d[i][7];
            dp_d[i] = (lit & show) ^ dp_active_low;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= '0;
            stale_q <= '1;
            seg_q   <= {w_digit{{7{seg_active_low}}}};
            dp_q    <= {w_digit{dp_active_low}};
        end else begin
            pat_q   <= pat_d;
            stale_q <= stale_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign hex_seg = seg_q;
    assign dp      = dp_q;
    assign stale   = stale_q;

endmodule
